// File: rtl/ram_arbiter.sv
// -----------------------------------------------------------------------------
// ram_arbiter
//
// Shares the single-port simulation data RAM between the instruction fetch
// unit (read-only) and the load/store unit (read/write). One access runs at a
// time:
//   IDLE   -> pick a requester (round-robin on contention), grant it
//             combinationally, and latch address, operation and store data.
//   ACCESS -> hold ram_cs plus ram_rd or ram_wr until the RAM reports
//             ram_ready, or until TIMEOUT_CYC cycles have passed.
//   DONE   -> drop ram_cs so the RAM's access counter clears, and pulse the
//             owner's rvalid for one cycle.
// This gives at least two cs-low cycles between accesses: DONE plus the
// IDLE/grant cycle.
//
// Ports
//   clk, rst                   clock; synchronous active-high reset
//   ifu_req/addr               fetch request (level) and byte address
//   ifu_gnt                    fetch accepted this cycle
//   ifu_rvalid/rdata/err       fetch response strobe, data and timeout flag
//   lsu_req/we/addr/wdata      load/store request, 1 = store, address, data
//   lsu_gnt                    load/store accepted this cycle
//   lsu_rvalid/rdata/err       load data or store ack, data, timeout flag
//   ram_cs/wr/rd               RAM select, write strobe, read strobe
//   ram_addr                   RAM word index (byte address >> ADDR_SHIFT)
//   ram_wdata                  RAM write data
//   ram_rdata, ram_ready       RAM registered read data, access complete
// -----------------------------------------------------------------------------
module ram_arbiter #(
  parameter int unsigned ADDR_SHIFT  = 2,
  parameter int unsigned TIMEOUT_CYC = 15
) (
  input  logic        clk,
  input  logic        rst,
  // instruction fetch unit
  input  logic        ifu_req,
  input  logic [31:0] ifu_addr,
  output logic        ifu_gnt,
  output logic        ifu_rvalid,
  output logic [31:0] ifu_rdata,
  output logic        ifu_err,
  // load/store unit
  input  logic        lsu_req,
  input  logic        lsu_we,
  input  logic [31:0] lsu_addr,
  input  logic [31:0] lsu_wdata,
  output logic        lsu_gnt,
  output logic        lsu_rvalid,
  output logic [31:0] lsu_rdata,
  output logic        lsu_err,
  // RAM side
  output logic        ram_cs,
  output logic        ram_wr,
  output logic        ram_rd,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata,
  input  logic        ram_ready
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_e;

  // The same encoding serves as access owner and round-robin pointer.
  typedef enum logic {
    OWN_LSU = 1'b0,
    OWN_IFU = 1'b1
  } owner_e;

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
  // Counter value in the last ACCESS cycle allowed before giving up.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  state_e           state_q,     state_d;
  owner_e           owner_q,     owner_d;
  owner_e           prio_q,      prio_d;
  logic             store_q,     store_d;
  logic [CNT_W-1:0] cnt_q,       cnt_d;
  logic [31:0]      addr_q,      addr_d;
  logic [31:0]      wdata_q,     wdata_d;
  logic [31:0]      ifu_rdata_q, ifu_rdata_d;
  logic [31:0]      lsu_rdata_q, lsu_rdata_d;
  logic             err_q,       err_d;

  // Arbitration decision, valid only in IDLE.
  logic lsu_wins;
  logic ifu_wins;

  always_comb begin
    lsu_wins = lsu_req && (!ifu_req || (prio_q == OWN_LSU));
    ifu_wins = ifu_req && !lsu_wins;
  end

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    prio_d      = prio_q;
    store_d     = store_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    ifu_rdata_d = ifu_rdata_q;
    lsu_rdata_d = lsu_rdata_q;
    err_d       = err_q;

    ifu_gnt     = 1'b0;
    lsu_gnt     = 1'b0;
    ifu_rvalid  = 1'b0;
    lsu_rvalid  = 1'b0;
    ifu_err     = 1'b0;
    lsu_err     = 1'b0;
    ram_cs      = 1'b0;
    ram_wr      = 1'b0;
    ram_rd      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // No grant is accepted while reset is held, since the state register
        // would discard it at this edge.
        if (!rst && (lsu_wins || ifu_wins)) begin
          state_d = S_ACCESS;
          cnt_d   = '0;
          if (lsu_wins) begin
            lsu_gnt = 1'b1;
            owner_d = OWN_LSU;
            store_d = lsu_we;
            addr_d  = lsu_addr >> ADDR_SHIFT;
            wdata_d = lsu_wdata;
          end else begin
            ifu_gnt = 1'b1;
            owner_d = OWN_IFU;
            store_d = 1'b0;
            addr_d  = ifu_addr >> ADDR_SHIFT;
          end
          // The pointer moves only when a request actually lost; a lone
          // requester leaves it where it was.
          if (lsu_req && ifu_req) begin
            prio_d = lsu_wins ? OWN_IFU : OWN_LSU;
          end
        end
      end

      S_ACCESS: begin
        ram_cs = 1'b1;
        ram_wr = store_q;
        ram_rd = !store_q;
        cnt_d  = cnt_q + CNT_W'(1);
        if (ram_ready) begin
          state_d = S_DONE;
          err_d   = 1'b0;
          if (!store_q) begin
            if (owner_q == OWN_LSU) lsu_rdata_d = ram_rdata;
            else                    ifu_rdata_d = ram_rdata;
          end
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_DONE;
          err_d   = 1'b1;
        end
      end

      S_DONE: begin
        // ram_cs stays low here: this is the cycle that clears the RAM's
        // access counter before the next access can start.
        state_d = S_IDLE;
        cnt_d   = '0;
        if (owner_q == OWN_LSU) begin
          lsu_rvalid = 1'b1;
          lsu_err    = err_q;
        end else begin
          ifu_rvalid = 1'b1;
          ifu_err    = err_q;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // NOTE: state updates use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, matching the hardware.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: these are a handful of flops, not a memory, so all of them are
      // reset; an access in flight is simply abandoned without a response.
      state_q     <= S_IDLE;
      owner_q     <= OWN_LSU;
      prio_q      <= OWN_LSU;
      store_q     <= 1'b0;
      cnt_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      ifu_rdata_q <= '0;
      lsu_rdata_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      prio_q      <= prio_d;
      store_q     <= store_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      ifu_rdata_q <= ifu_rdata_d;
      lsu_rdata_q <= lsu_rdata_d;
      err_q       <= err_d;
    end
  end

  assign ram_addr  = addr_q;
  assign ram_wdata = wdata_q;
  assign ifu_rdata = ifu_rdata_q;
  assign lsu_rdata = lsu_rdata_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_ram_arbiter
//
// Bench for ram_arbiter. It contains a behavioural copy of the data RAM: the
// RAM counts consecutive cs-high cycles and raises ready on the fourth, read
// data is registered, and a store commits on the ready edge. A transaction-
// level reference model predicts every DUT output on every cycle. Directed
// scenarios add literal expectations for latency, grant order and data.
// -----------------------------------------------------------------------------
module tb_ram_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ifu_req = 1'b0;
  logic [31:0] ifu_addr = '0;
  logic        ifu_gnt, ifu_rvalid, ifu_err;
  logic [31:0] ifu_rdata;
  logic        lsu_req = 1'b0;
  logic        lsu_we = 1'b0;
  logic [31:0] lsu_addr = '0;
  logic [31:0] lsu_wdata = '0;
  logic        lsu_gnt, lsu_rvalid, lsu_err;
  logic [31:0] lsu_rdata;
  logic        ram_cs, ram_wr, ram_rd, ram_ready;
  logic [31:0] ram_addr, ram_wdata;
  logic [31:0] ram_rdata = '0;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  ram_arbiter #(.ADDR_SHIFT(2), .TIMEOUT_CYC(15)) dut (
    .clk(clk), .rst(rst),
    .ifu_req(ifu_req), .ifu_addr(ifu_addr), .ifu_gnt(ifu_gnt),
    .ifu_rvalid(ifu_rvalid), .ifu_rdata(ifu_rdata), .ifu_err(ifu_err),
    .lsu_req(lsu_req), .lsu_we(lsu_we), .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
    .lsu_gnt(lsu_gnt), .lsu_rvalid(lsu_rvalid), .lsu_rdata(lsu_rdata), .lsu_err(lsu_err),
    .ram_cs(ram_cs), .ram_wr(ram_wr), .ram_rd(ram_rd), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .ram_ready(ram_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  // ---------------------------------------------------------------- RAM model
  logic [31:0] mem [0:63];
  int          ram_cnt  = 0;
  bit          ready_en = 1'b1;
  bit          pl_we    = 1'b0;
  logic [5:0]  pl_idx   = '0;
  logic [31:0] pl_data  = '0;

  assign ram_ready = ready_en && ram_cs && (ram_cnt >= 3);

  always @(posedge clk) begin
    if (pl_we) mem[pl_idx] <= pl_data;
    if (ram_cs) begin
      ram_cnt <= ram_cnt + 1;
      if (ram_rd) ram_rdata <= mem[ram_addr[5:0]];
      if (ram_wr && ram_ready) mem[ram_addr[5:0]] <= ram_wdata;
    end else begin
      ram_cnt <= 0;
    end
  end

  // -------------------------------------------------------- reference model
  typedef struct { int cyc; bit lsu; } gnt_ev_t;
  gnt_ev_t gnt_log[$];

  always @(negedge clk) begin : cmp
    // Transaction-level view: busy from grant to response; the response
    // cycle follows either the ready cycle or the 15th access cycle.
    static bit          m_busy = 0, m_rsp = 0, m_lsu = 0, m_store = 0, m_err = 0;
    static bit          m_ptr_lsu = 1;
    static int          m_acc = 0;
    static logic [31:0] m_addr = '0, m_wdata = '0, m_ifu_rdata = '0, m_lsu_rdata = '0;
    static int          cs_low_run = 0, cs_high_run = 0;
    static bit          seen_access = 0;
    bit w_lsu, w_ifu, in_acc;
    if (cyc > 0) begin
      w_lsu  = !m_busy && !rst && lsu_req && (!ifu_req || m_ptr_lsu);
      w_ifu  = !m_busy && !rst && ifu_req && !w_lsu;
      in_acc = m_busy && !m_rsp;
      check("ifu_gnt",    ifu_gnt,    w_ifu);
      check("lsu_gnt",    lsu_gnt,    w_lsu);
      check("ram_cs",     ram_cs,     in_acc);
      check("ram_rd",     ram_rd,     in_acc && !m_store);
      check("ram_wr",     ram_wr,     in_acc && m_store);
      check("ram_addr",   ram_addr,   m_addr);
      check("ram_wdata",  ram_wdata,  m_wdata);
      check("ifu_rvalid", ifu_rvalid, m_rsp && !m_lsu);
      check("lsu_rvalid", lsu_rvalid, m_rsp && m_lsu);
      check("ifu_err",    ifu_err,    m_rsp && !m_lsu && m_err);
      check("lsu_err",    lsu_err,    m_rsp && m_lsu && m_err);
      check("ifu_rdata",  ifu_rdata,  m_ifu_rdata);
      check("lsu_rdata",  lsu_rdata,  m_lsu_rdata);

      if (ifu_gnt || lsu_gnt) gnt_log.push_back('{cyc, lsu_gnt});

      // Gap between accesses and earliest ready, measured on the DUT's cs.
      if (ram_cs) begin
        if (cs_high_run == 0 && seen_access) check("cs_gap", 32'(cs_low_run >= 1), 1);
        check("ready_early", 32'(ram_ready && cs_high_run < 3), 0);
        cs_high_run++;
        cs_low_run  = 0;
        seen_access = 1;
      end else begin
        cs_high_run = 0;
        cs_low_run++;
      end

      // Advance the model by one cycle.
      if (rst) begin
        m_busy = 0; m_rsp = 0; m_lsu = 0; m_store = 0; m_err = 0; m_ptr_lsu = 1;
        m_acc = 0; m_addr = '0; m_wdata = '0; m_ifu_rdata = '0; m_lsu_rdata = '0;
      end else if (!m_busy) begin
        if (w_lsu || w_ifu) begin
          m_busy  = 1;
          m_rsp   = 0;
          m_acc   = 0;
          m_lsu   = w_lsu;
          m_store = w_lsu && lsu_we;
          m_addr  = (w_lsu ? lsu_addr : ifu_addr) >> 2;
          if (w_lsu) m_wdata = lsu_wdata;
          if (lsu_req && ifu_req) m_ptr_lsu = !w_lsu;
        end
      end else if (!m_rsp) begin
        m_acc++;
        if (ram_ready) begin
          m_rsp = 1;
          m_err = 0;
          if (!m_store) begin
            if (m_lsu) m_lsu_rdata = mem[m_addr[5:0]];
            else       m_ifu_rdata = mem[m_addr[5:0]];
          end
        end else if (m_acc == 15) begin
          m_rsp = 1;
          m_err = 1;
        end
      end else begin
        m_busy = 0;
        m_rsp  = 0;
      end
    end
  end

  // ---------------------------------------------------------------- stimulus
  task automatic do_req(input bit is_lsu, input bit we, input logic [31:0] addr,
                        input logic [31:0] wdata, output int lat, output logic [31:0] rdata,
                        output logic err, output int cs_cycles, output logic cs_at_rsp,
                        output logic [31:0] acc_addr);
    int t_gnt = 0;
    bit got   = 0;
    if (is_lsu) begin
      lsu_req = 1'b1; lsu_we = we; lsu_addr = addr; lsu_wdata = wdata;
    end else begin
      ifu_req = 1'b1; ifu_addr = addr;
    end
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (is_lsu ? lsu_gnt : ifu_gnt) begin got = 1; t_gnt = cyc; end
    end
    check("gnt_wait", 32'(got), 1);
    @(posedge clk); #1;
    ifu_req = 1'b0; lsu_req = 1'b0;
    got = 0; lat = -1; rdata = '0; err = 1'b0; cs_cycles = 0; cs_at_rsp = 1'b1; acc_addr = '0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (ram_cs) begin
        if (cs_cycles == 0) acc_addr = ram_addr;
        cs_cycles++;
      end
      if (is_lsu ? lsu_rvalid : ifu_rvalid) begin
        got = 1;
        lat = cyc - t_gnt;
        rdata = is_lsu ? lsu_rdata : ifu_rdata;
        err = is_lsu ? lsu_err : ifu_err;
        cs_at_rsp = ram_cs;
      end
    end
    check("rsp_wait", 32'(got), 1);
  endtask

  initial begin
    repeat (5000) @(posedge clk);
    $display("FAIL watchdog: bench did not finish within 5000 cycles");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, csn, base;
    logic [31:0] rd, aa;
    logic er, csr;

    // Reset and preload mem[4].
    rst = 1'b1;
    pl_we = 1'b1; pl_idx = 6'd4; pl_data = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    pl_we = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ram_cs", ram_cs, 0);
    check("rst_ram_addr", ram_addr, 0);
    check("rst_ifu_rdata", ifu_rdata, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) @(posedge clk); #1;

    // Single IFU read of 0x10 -> word 4.
    do_req(0, 0, 32'h10, '0, lat, rd, er, csn, csr, aa);
    check("ifu_lat", lat, 5);
    check("ifu_data", rd, 32'hDEAD_BEEF);
    check("ifu_err_ok", er, 0);
    check("ifu_acc_cycles", csn, 4);
    check("ifu_acc_addr", aa, 32'd4);
    @(posedge clk); #1;

    // Store then load of 0x8 -> word 2.
    do_req(1, 1, 32'h8, 32'h1234_5678, lat, rd, er, csn, csr, aa);
    check("st_lat", lat, 5);
    check("st_rdata_kept", rd, 0);
    check("st_mem2", mem[2], 32'h1234_5678);
    @(posedge clk); #1;
    do_req(1, 0, 32'h8, '0, lat, rd, er, csn, csr, aa);
    check("ld_lat", lat, 5);
    check("ld_data", rd, 32'h1234_5678);

    // Contention: both requests held from reset.
    @(posedge clk); #1;
    rst = 1'b1;
    ifu_req = 1'b1; ifu_addr = 32'h10;
    lsu_req = 1'b1; lsu_we = 1'b0; lsu_addr = 32'h8;
    repeat (2) @(posedge clk); #1;
    base = gnt_log.size();
    rst = 1'b0;
    for (int i = 0; i < 60 && gnt_log.size() < base + 4; i++) @(negedge clk);
    check("rr_count", 32'(gnt_log.size() >= base + 4), 1);
    @(posedge clk); #1;
    ifu_req = 1'b0; lsu_req = 1'b0;
    if (gnt_log.size() >= base + 4) begin
      check("rr_0_lsu", gnt_log[base].lsu, 1);
      check("rr_1_ifu", gnt_log[base+1].lsu, 0);
      check("rr_2_lsu", gnt_log[base+2].lsu, 1);
      check("rr_3_ifu", gnt_log[base+3].lsu, 0);
      for (int k = 1; k < 4; k++)
        check("rr_gap", gnt_log[base+k].cyc - gnt_log[base+k-1].cyc, 6);
    end
    repeat (12) @(posedge clk); #1;

    // Timeout: RAM never answers.
    ready_en = 1'b0;
    do_req(1, 0, 32'h8, '0, lat, rd, er, csn, csr, aa);
    check("to_lat", lat, 16);
    check("to_err", er, 1);
    check("to_acc_cycles", csn, 15);
    check("to_cs_done", csr, 0);
    check("to_rdata_kept", rd, 32'h1234_5678);
    ready_en = 1'b1;
    repeat (2) @(posedge clk); #1;

    // Reset in the second ACCESS cycle of an IFU read.
    ifu_req = 1'b1; ifu_addr = 32'h10;
    begin
      bit got = 0;
      for (int i = 0; i < 20 && !got; i++) begin
        @(negedge clk);
        got = ifu_gnt;
      end
      check("rm_gnt", 32'(got), 1);
    end
    @(posedge clk); #1;        // cycle T+1
    ifu_req = 1'b0;
    @(posedge clk); #1;        // cycle T+2
    rst = 1'b1;
    @(posedge clk); #1;        // cycle T+3
    rst = 1'b0;
    @(negedge clk);
    check("rm_cs", ram_cs, 0);
    check("rm_rd", ram_rd, 0);
    check("rm_addr", ram_addr, 0);
    check("rm_ifu_rdata", ifu_rdata, 0);
    begin
      int seen = 0;
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        if (ifu_rvalid) seen++;
      end
      check("rm_no_rvalid", seen, 0);
    end
    @(posedge clk); #1;
    do_req(0, 0, 32'h10, '0, lat, rd, er, csn, csr, aa);
    check("rm_after_lat", lat, 5);
    check("rm_after_data", rd, 32'hDEAD_BEEF);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Two-requester arbiter and sequencer for the single-port simulation data RAM (ram_db) in the core.
- Shares the RAM between the instruction fetch unit (IFU, read-only) and the load/store unit (LSU, read/write).
- Drives the RAM's cs/wr/rd/address/data signals and waits for the RAM's counted ready pulse. Returns a one-cycle response to the granted requester.
- Guarantees at least one cs-low cycle between accesses so the RAM's access counter clears.

Parameters:
- ADDR_SHIFT, 2, right shift applied to the requester byte address to form the RAM word index.
- TIMEOUT_CYC, 15, maximum ACCESS cycles to wait for ram_ready before aborting with an error.

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- ifu_req  in  1  fetch request (level, held until ifu_gnt)
- ifu_addr  in  32  fetch byte address
- ifu_gnt  out  1  request accepted this cycle
- ifu_rvalid  out  1  one-cycle response strobe
- ifu_rdata  out  32  fetched word, valid with ifu_rvalid
- ifu_err  out  1  timeout flag, valid with ifu_rvalid
- lsu_req  in  1  load/store request (level, held until lsu_gnt)
- lsu_we  in  1  1 = store, 0 = load
- lsu_addr  in  32  byte address
- lsu_wdata  in  32  store data
- lsu_gnt  out  1  request accepted this cycle
- lsu_rvalid  out  1  one-cycle response strobe (load data or store ack)
- lsu_rdata  out  32  load data, valid with lsu_rvalid
- lsu_err  out  1  timeout flag, valid with lsu_rvalid
- ram_cs  out  1  RAM select
- ram_wr  out  1  RAM write
- ram_rd  out  1  RAM read
- ram_addr  out  32  RAM word index
- ram_wdata  out  32  RAM write data
- ram_rdata  in  32  RAM registered read data
- ram_ready  in  1  RAM access-complete indication

Behaviour:
- Reset:
  - Synchronous, active-high. Reset values: state IDLE, priority pointer = LSU, timeout counter 0.
  - All outputs 0 at reset: ram_cs/wr/rd, gnt, rvalid, err, rdata, ram_addr, ram_wdata.
  - Reset asserted mid-access returns to IDLE at that edge, drops ram_cs, and produces no response.
- States: IDLE, ACCESS, DONE.
- IDLE:
  - ram_cs = 0.
  - If any request is present, the winner's gnt is asserted combinationally this cycle.
  - On the edge, latch owner, op, ram_addr = addr >> ADDR_SHIFT, and ram_wdata (LSU only), then go to ACCESS.
  - Arbitration is round-robin. If both request, the pointer side wins and the pointer then flips to the other side. A single requester always wins.
- ACCESS:
  - ram_cs = 1.
  - Read (IFU, or LSU with we = 0): ram_rd = 1, ram_wr = 0.
  - Store: ram_wr = 1, ram_rd = 0.
  - ram_wr and ram_rd are never both 1.
  - Address and data are held stable for the whole state.
  - On an edge with ram_ready = 1: capture ram_rdata into the owner's rdata register (reads only; a store leaves rdata unchanged), clear err, go to DONE.
  - The timeout counter increments on every ACCESS cycle. If it reaches TIMEOUT_CYC without ram_ready, set err = 1 for the owner and go to DONE; rdata is unchanged.
- DONE:
  - ram_cs = 0, which clears the RAM counter.
  - Owner's rvalid = 1 for exactly this cycle.
  - Return to IDLE and clear the timeout counter.
- Latency:
  - With the RAM's three-edge ready, gnt is in cycle T, ACCESS runs T+1..T+4 (ready seen in T+4), and rvalid is in T+5.
  - The next gnt is no earlier than T+6, so there are two cs-low cycles between accesses.
- Requests are ignored outside IDLE. gnt is 0 in ACCESS and DONE.
- A requester must not change addr/we/wdata in the gnt cycle.
- The non-owner's rvalid and err are always 0.

Test Plan:
- Single IFU read: preload mem[4] = 32'hDEAD_BEEF, set ifu_req = 1 with ifu_addr = 32'h10. Expect ifu_gnt at T, ram_addr = 4 with ram_cs = ram_rd = 1 during T+1..T+4, ifu_rvalid in T+5 with ifu_rdata = 32'hDEAD_BEEF and ifu_err = 0.
- LSU store then load: store lsu_addr = 32'h8, lsu_wdata = 32'h1234_5678, then load the same address. Expect the store rvalid with lsu_rdata unchanged and mem[2] = 32'h1234_5678, then load rvalid with lsu_rdata = 32'h1234_5678. ram_wr and ram_rd are never both high.
- Contention: hold ifu_req and lsu_req high continuously from reset. Expect grants in the order LSU, IFU, LSU, IFU, and each gnt exactly 6 cycles apart.
- cs gap: across back-to-back transactions, ram_cs is low for at least 1 cycle between ACCESS periods, and ram_ready never asserts within the first 3 cycles of any ACCESS.
- Timeout: tie ram_ready to 0 and issue an LSU load. Expect lsu_rvalid with lsu_err = 1 after 15 ACCESS cycles, and ram_cs to drop in DONE.
- Reset mid-op: assert rst during cycle T+2 of an IFU read. Next cycle expect ram_cs = 0, state IDLE, no ifu_rvalid, and all outputs 0. A subsequent request completes normally.
